// File: rtl/cachepool_l2_arbiter.sv
// Round-robin scheduler from cache-controller refill/writeback ports onto address-interleaved
// L2 channels. Define CACHEPOOL_L2_ARB_STATS_EN for per-channel grant/stall counters.
module cachepool_l2_arbiter #(
    parameter int NumReq         = 4,
    parameter int NumChan        = 2,
    parameter int AddrWidth      = 32,
    parameter int ChanSelBit     = 30,
    parameter int MaxOutstanding = 4,
    localparam int SrcWidth      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumReq-1:0]            req_valid_i,
    output logic [NumReq-1:0]            req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]  req_addr_i,
    input  logic [NumReq-1:0]            req_write_i,
    output logic [NumChan-1:0]           chan_req_valid_o,
    input  logic [NumChan-1:0]           chan_req_ready_i,
    output logic [NumChan*AddrWidth-1:0] chan_req_addr_o,
    output logic [NumChan-1:0]           chan_req_write_o,
    output logic [NumChan*SrcWidth-1:0]  chan_req_src_o,
    input  logic [NumChan-1:0]           chan_rsp_valid_i,
    input  logic [NumChan*SrcWidth-1:0]  chan_rsp_src_i,
    output logic [NumChan-1:0]           chan_rsp_ready_o,
    output logic [NumReq-1:0]            rsp_valid_o,
    input  logic [NumReq-1:0]            rsp_ready_i,
    output logic [NumChan*32-1:0]        stat_grant_o,
    output logic [NumChan*32-1:0]        stat_stall_o
);

    localparam int ChanBits = (NumChan > 1) ? $clog2(NumChan) : 1;
    localparam int CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    logic [CntWidth-1:0]  cnt_reg     [NumReq];
    logic [ChanBits-1:0]  tgt         [NumReq];
    logic [NumReq-1:0]    elig        [NumChan];
    logic [NumChan-1:0]   chan_free;
    logic [NumChan-1:0]   grant_vld;
    logic [SrcWidth-1:0]  grant_idx   [NumChan];
    logic [SrcWidth-1:0]  rr_ptr_reg  [NumChan];
    logic                 vld_reg     [NumChan];
    logic [AddrWidth-1:0] addr_reg    [NumChan];
    logic                 write_reg   [NumChan];
    logic [SrcWidth-1:0]  src_reg     [NumChan];
    logic [NumReq-1:0]    rsp_hs;

    genvar gi;

    // Channel steering follows the DRAM interleave field of each request address.
    generate
        for (gi = 0; gi < NumReq; gi++) begin : g_tgt
            if (NumChan > 1) begin : g_sel
                assign tgt[gi] = req_addr_i[gi*AddrWidth + ChanSelBit +: ChanBits];
            end else begin : g_single
                assign tgt[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        for (int c = 0; c < NumChan; c++) begin
            for (int i = 0; i < NumReq; i++) begin
                elig[c][i] = req_valid_i[i] && (tgt[i] == ChanBits'(c)) && (cnt_reg[i] < CntMax);
            end
        end
    end

    // Each free channel scans requesters starting at its round-robin pointer.
    always_comb begin
        int idx;
        idx = 0;
        for (int c = 0; c < NumChan; c++) begin
            grant_vld[c] = 1'b0;
            grant_idx[c] = '0;
            if (chan_free[c]) begin
                for (int k = 0; k < NumReq; k++) begin
                    idx = (int'(rr_ptr_reg[c]) + k) % NumReq;
                    if (!grant_vld[c] && elig[c][idx]) begin
                        grant_vld[c] = 1'b1;
                        grant_idx[c] = SrcWidth'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int c = 0; c < NumChan; c++) begin
            if (grant_vld[c]) begin
                req_ready_o[grant_idx[c]] = 1'b1;
            end
        end
    end

    // Responses: lowest-indexed channel carrying a given src wins; others wait.
    always_comb begin
        logic found;
        rsp_valid_o      = '0;
        chan_rsp_ready_o = '0;
        found            = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            found = 1'b0;
            for (int c = 0; c < NumChan; c++) begin
                if (!found && chan_rsp_valid_i[c] &&
                    (chan_rsp_src_i[c*SrcWidth +: SrcWidth] == SrcWidth'(i))) begin
                    found               = 1'b1;
                    rsp_valid_o[i]      = 1'b1;
                    chan_rsp_ready_o[c] = rsp_ready_i[i];
                end
            end
        end
    end

    assign rsp_hs = rsp_valid_o & rsp_ready_i;

    generate
        for (gi = 0; gi < NumChan; gi++) begin : g_chan
            assign chan_free[gi] = !vld_reg[gi] || chan_req_ready_i[gi];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_reg[gi]    <= 1'b0;
                    addr_reg[gi]   <= '0;
                    write_reg[gi]  <= 1'b0;
                    src_reg[gi]    <= '0;
                    rr_ptr_reg[gi] <= '0;
                end else if (grant_vld[gi]) begin
                    vld_reg[gi]    <= 1'b1;
                    addr_reg[gi]   <= req_addr_i[int'(grant_idx[gi])*AddrWidth +: AddrWidth];
                    write_reg[gi]  <= req_write_i[grant_idx[gi]];
                    src_reg[gi]    <= grant_idx[gi];
                    rr_ptr_reg[gi] <= SrcWidth'((int'(grant_idx[gi]) + 1) % NumReq);
                end else if (chan_req_ready_i[gi]) begin
                    vld_reg[gi]    <= 1'b0;
                end
            end

            assign chan_req_valid_o[gi]                          = vld_reg[gi];
            assign chan_req_addr_o[gi*AddrWidth +: AddrWidth]    = addr_reg[gi];
            assign chan_req_write_o[gi]                          = write_reg[gi];
            assign chan_req_src_o[gi*SrcWidth +: SrcWidth]       = src_reg[gi];
        end
    endgenerate

    // Simultaneous issue and completion leave the count unchanged; stray responses saturate at 0.
    generate
        for (gi = 0; gi < NumReq; gi++) begin : g_cnt
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg[gi] <= '0;
                end else if (req_ready_o[gi] && !rsp_hs[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CntWidth'(1);
                end else if (!req_ready_o[gi] && rsp_hs[gi] && (cnt_reg[gi] != '0)) begin
                    cnt_reg[gi] <= cnt_reg[gi] - CntWidth'(1);
                end
            end
        end
    endgenerate

`ifdef CACHEPOOL_L2_ARB_STATS_EN
    logic [31:0] grant_cnt_reg [NumChan];
    logic [31:0] stall_cnt_reg [NumChan];

    generate
        for (gi = 0; gi < NumChan; gi++) begin : g_stats
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    grant_cnt_reg[gi] <= '0;
                    stall_cnt_reg[gi] <= '0;
                end else begin
                    if (grant_vld[gi]) begin
                        grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 32'd1;
                    end
                    if (vld_reg[gi] && !chan_req_ready_i[gi]) begin
                        stall_cnt_reg[gi] <= stall_cnt_reg[gi] + 32'd1;
                    end
                end
            end
            assign stat_grant_o[gi*32 +: 32] = grant_cnt_reg[gi];
            assign stat_stall_o[gi*32 +: 32] = stall_cnt_reg[gi];
        end
    endgenerate
`else
    assign stat_grant_o = '0;
    assign stat_stall_o = '0;
`endif

endmodule

// File: tb/tb_cachepool_l2_arbiter.sv
// Directed bench for cachepool_l2_arbiter with a per-cycle behavioural model and literal spot checks.
module tb_cachepool_l2_arbiter;

    localparam int NR = 4;
    localparam int NC = 2;
    localparam int AW = 32;
    localparam int SW = 2;
`ifdef CACHEPOOL_L2_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [NR-1:0] req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NC-1:0] chan_req_valid, chan_req_ready, chan_req_write, chan_rsp_valid, chan_rsp_ready;
    logic [NC*AW-1:0] chan_req_addr;
    logic [NC*SW-1:0] chan_req_src, chan_rsp_src;
    logic [NC*32-1:0] stat_grant, stat_stall;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cachepool_l2_arbiter dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_addr_i       (req_addr),
        .req_write_i      (req_write),
        .chan_req_valid_o (chan_req_valid),
        .chan_req_ready_i (chan_req_ready),
        .chan_req_addr_o  (chan_req_addr),
        .chan_req_write_o (chan_req_write),
        .chan_req_src_o   (chan_req_src),
        .chan_rsp_valid_i (chan_rsp_valid),
        .chan_rsp_src_i   (chan_rsp_src),
        .chan_rsp_ready_o (chan_rsp_ready),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .stat_grant_o     (stat_grant),
        .stat_stall_o     (stat_stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt [NR];
    int          m_rr  [NC];
    bit          m_vld [NC];
    logic [31:0] m_addr[NC];
    bit          m_wr  [NC];
    int          m_src [NC];
    int          m_sg  [NC];
    int          m_ss  [NC];
    int          g     [NC];
    int          rc    [NR];
    logic [NR-1:0] e_rdy, e_rv;
    logic [NC-1:0] e_crr;

    function automatic int pick(int c);
        int i;
        for (int k = 0; k < NR; k++) begin
            i = (m_rr[c] + k) % NR;
            if (req_valid[i] && int'(req_addr[i*AW + 30]) == c && m_cnt[i] < 4) return i;
        end
        return -1;
    endfunction

    function automatic int rsp_chan(int i);
        for (int c = 0; c < NC; c++) begin
            if (chan_rsp_valid[c] && int'(chan_rsp_src[c*SW +: SW]) == i) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_ni) begin
            for (int c = 0; c < NC; c++) begin
                m_vld[c] = 1'b0; m_addr[c] = '0; m_wr[c] = 1'b0; m_src[c] = 0;
                m_rr[c] = 0; m_sg[c] = 0; m_ss[c] = 0;
            end
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
            check("m_rst_cvalid", 64'(chan_req_valid), 64'(0));
        end else begin
            e_rdy = '0; e_rv = '0; e_crr = '0;
            for (int c = 0; c < NC; c++) begin
                g[c] = (!m_vld[c] || chan_req_ready[c]) ? pick(c) : -1;
                if (g[c] >= 0) e_rdy[g[c]] = 1'b1;
            end
            for (int i = 0; i < NR; i++) begin
                rc[i] = rsp_chan(i);
                if (rc[i] >= 0) begin
                    e_rv[i] = 1'b1;
                    e_crr[rc[i]] = rsp_ready[i];
                end
            end
            check("m_req_ready", 64'(req_ready), 64'(e_rdy));
            check("m_rsp_valid", 64'(rsp_valid), 64'(e_rv));
            check("m_chan_rsp_ready", 64'(chan_rsp_ready), 64'(e_crr));
            for (int c = 0; c < NC; c++) begin
                check($sformatf("m_cvalid%0d", c), 64'(chan_req_valid[c]), 64'(m_vld[c]));
                if (m_vld[c]) begin
                    check($sformatf("m_caddr%0d", c), 64'(chan_req_addr[c*AW +: AW]), 64'(m_addr[c]));
                    check($sformatf("m_cwr%0d", c), 64'(chan_req_write[c]), 64'(m_wr[c]));
                    check($sformatf("m_csrc%0d", c), 64'(chan_req_src[c*SW +: SW]), 64'(m_src[c]));
                end
                check($sformatf("m_sgrant%0d", c), 64'(stat_grant[c*32 +: 32]), STATS ? 64'(m_sg[c]) : 64'(0));
                check($sformatf("m_sstall%0d", c), 64'(stat_stall[c*32 +: 32]), STATS ? 64'(m_ss[c]) : 64'(0));
            end
            // advance to the state after the coming rising edge
            for (int i = 0; i < NR; i++) begin
                if (e_rdy[i] && !(e_rv[i] && rsp_ready[i])) m_cnt[i]++;
                else if (!e_rdy[i] && e_rv[i] && rsp_ready[i] && m_cnt[i] > 0) m_cnt[i]--;
            end
            for (int c = 0; c < NC; c++) begin
                if (m_vld[c] && !chan_req_ready[c]) m_ss[c]++;
                if (g[c] >= 0) begin
                    m_vld[c]  = 1'b1;
                    m_addr[c] = req_addr[g[c]*AW +: AW];
                    m_wr[c]   = req_write[g[c]];
                    m_src[c]  = g[c];
                    m_sg[c]++;
                    m_rr[c]   = (g[c] + 1) % NR;
                end else if (chan_req_ready[c]) begin
                    m_vld[c] = 1'b0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_write = '0;
        chan_rsp_valid = '0;
        chan_rsp_src = '0;
        chan_req_ready = '1;
        rsp_ready = '1;
    endtask

    task automatic drive(input int i, input logic [31:0] a, input logic w);
        req_valid[i] = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_write[i] = w;
    endtask

    task automatic do_reset();
        idle();
        #1 rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_ni = 1'b1;
    endtask

    initial begin
        req_addr = '0;
        idle();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_ni = 1'b1;

        tick();
        #1;
        check("rst_cvalid", 64'(chan_req_valid), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_chan_rsp_ready", 64'(chan_rsp_ready), 64'(0));
        check("rst_caddr", chan_req_addr, 64'(0));
        check("rst_csrc", 64'(chan_req_src), 64'(0));

        // single request
        tick();
        drive(0, 32'h8000_0040, 1'b0);
        #1 check("t1_ready", 64'(req_ready), 64'(4'b0001));
        tick();
        idle();
        #1;
        check("t1_cvalid", 64'(chan_req_valid), 64'(2'b01));
        check("t1_addr", 64'(chan_req_addr[31:0]), 64'(32'h8000_0040));
        check("t1_src", 64'(chan_req_src[1:0]), 64'(0));
        check("t1_write", 64'(chan_req_write[0]), 64'(0));

        // channel steering, parallel grants
        tick();
        drive(1, 32'hC000_0000, 1'b1);
        drive(2, 32'h8000_0000, 1'b0);
        #1 check("t2_ready", 64'(req_ready), 64'(4'b0110));
        tick();
        idle();
        #1;
        check("t2_cvalid", 64'(chan_req_valid), 64'(2'b11));
        check("t2_src1", 64'(chan_req_src[3:2]), 64'(1));
        check("t2_src0", 64'(chan_req_src[1:0]), 64'(2));
        check("t2_addr1", 64'(chan_req_addr[63:32]), 64'(32'hC000_0000));
        check("t2_write1", 64'(chan_req_write[1]), 64'(1));

        // round-robin on channel 0, then a 3-cycle stall
        do_reset();
        tick();
        for (int i = 0; i < NR; i++) drive(i, 32'h8000_0000 | (i << 4), 1'b0);
        for (int n = 0; n < 5; n++) begin
            #1 check($sformatf("rr_%0d", n), 64'(req_ready), 64'(4'b0001 << (n % 4)));
            tick();
        end
        req_valid = 4'b0010;
        chan_req_ready = 2'b00;
        for (int n = 0; n < 3; n++) begin
            #1;
            check($sformatf("stall_ready_%0d", n), 64'(req_ready), 64'(0));
            check($sformatf("stall_hold_%0d", n), 64'(chan_req_addr[31:0]), 64'(32'h8000_0000));
            tick();
        end
        chan_req_ready = 2'b11;
        #1;
        check("stat_stall0", 64'(stat_stall[31:0]), STATS ? 64'(3) : 64'(0));
        check("stat_grant0", 64'(stat_grant[31:0]), STATS ? 64'(5) : 64'(0));
        check("rr_after_stall", 64'(req_ready), 64'(4'b0010));
        tick();
        idle();

        // outstanding limit
        do_reset();
        tick();
        drive(0, 32'h0000_1000, 1'b0);
        for (int n = 0; n < 4; n++) begin
            #1 check($sformatf("os_grant_%0d", n), 64'(req_ready), 64'(4'b0001));
            tick();
        end
        #1 check("os_block", 64'(req_ready), 64'(0));
        tick();
        chan_rsp_valid = 2'b01;
        chan_rsp_src = 4'b0000;
        #1;
        check("os_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        check("os_rsp_ready", 64'(chan_rsp_ready), 64'(2'b01));
        check("os_block_same", 64'(req_ready), 64'(0));
        tick();
        chan_rsp_valid = 2'b00;
        #1 check("os_regrant", 64'(req_ready), 64'(4'b0001));
        tick();
        idle();

        // response collision for requester 2
        drive(2, 32'h8000_0200, 1'b0);
        for (int n = 0; n < 2; n++) begin
            #1 check($sformatf("col_issue_%0d", n), 64'(req_ready), 64'(4'b0100));
            tick();
        end
        idle();
        chan_rsp_valid = 2'b11;
        chan_rsp_src = {2'd2, 2'd2};
        #1;
        check("col_rsp_valid_a", 64'(rsp_valid), 64'(4'b0100));
        check("col_chan_ready_a", 64'(chan_rsp_ready), 64'(2'b01));
        tick();
        chan_rsp_valid = 2'b10;
        #1;
        check("col_rsp_valid_b", 64'(rsp_valid), 64'(4'b0100));
        check("col_chan_ready_b", 64'(chan_rsp_ready), 64'(2'b10));
        tick();
        idle();
        drive(2, 32'h8000_0200, 1'b0);
        for (int n = 0; n < 5; n++) begin
            #1 check($sformatf("col_refill_%0d", n), 64'(req_ready), (n < 4) ? 64'(4'b0100) : 64'(0));
            tick();
        end
        idle();

        // response to a requester with nothing outstanding, with and without backpressure
        chan_rsp_valid = 2'b01;
        chan_rsp_src = 4'b0011;
        rsp_ready = 4'b0111;
        #1;
        check("zero_rsp_valid", 64'(rsp_valid), 64'(4'b1000));
        check("zero_bp_ready", 64'(chan_rsp_ready), 64'(0));
        tick();
        rsp_ready = 4'b1111;
        #1 check("zero_rsp_ready", 64'(chan_rsp_ready), 64'(2'b01));
        tick();
        idle();

        // async reset with both output registers full
        chan_req_ready = 2'b00;
        drive(3, 32'h8000_0300, 1'b0);
        drive(1, 32'hC000_0100, 1'b1);
        #1 check("ar_grant", 64'(req_ready), 64'(4'b1010));
        tick();
        idle();
        chan_req_ready = 2'b00;
        #1 check("ar_full", 64'(chan_req_valid), 64'(2'b11));
        #1 rst_ni = 1'b0;
        idle();
        #1 check("ar_cleared", 64'(chan_req_valid), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst_ni = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) drive(i, 32'h8000_0000, 1'b0);
        #1 check("ar_rr_start", 64'(req_ready), 64'(4'b0001));
        tick();
        idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
